bcd_to_binary: RTL
==================

BCD_TO_BINARY -- requirements
Module: bcd_to_binary

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle request; digits are sampled when start=1 in IDLE.
REQ-005 hundreds  input  4  BCD hundreds digit.
REQ-006 tens  input  4  BCD tens digit.
REQ-007 ones  input  4  BCD ones digit.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  one-cycle pulse when the result is valid.
REQ-010 number  output  10  binary result (0..999), held until the next accepted start.
REQ-011 ovf8  output  1  result >255 (does not fit the 8-bit datapath), held with number.
REQ-012 err  output  1  invalid digit flag, held with number (see Configuration).

Function
REQ-013 Algorithm SHALL be reverse double-dabble on a 22-bit shift register {hundreds,tens,ones,10'b0}.
REQ-014 Each iteration: shift the register right by 1, then subtract 3 from every BCD nibble whose value is >=8.
REQ-015 After exactly 10 iterations, register bits [9:0] SHALL equal 100*hundreds+10*tens+ones.
REQ-016 FSM states SHALL be IDLE, SHIFT and DONE.
  - IDLE->SHIFT on start.
  - SHIFT->DONE when iteration counter=9.
  - DONE->IDLE unconditionally.
REQ-017 Timing, with start sampled at edge N:
  - busy=1 for cycles N+1..N+10.
  - done=1 and number/ovf8/err updated in cycle N+11 only.
  - busy=0 while done=1.
REQ-018 start while busy or done SHALL be ignored, with no effect on the result or timing.
REQ-019 start in the same cycle that done is high SHALL be ignored; a new start is accepted back in IDLE.
REQ-020 Digits SHALL be captured at acceptance; later input changes SHALL not affect the running conversion.
REQ-021 ovf8 SHALL be 1 iff number>255.
REQ-022 Arithmetic SHALL be unsigned; the nibble adjust never underflows for valid digits.

Reset
REQ-023 rst_n=0 SHALL force IDLE immediately, including mid-conversion, discarding any partial result.
REQ-024 During reset, busy, done, number, ovf8, err, the iteration counter and the shift register SHALL all be 0.
REQ-025 The first start after reset release SHALL be accepted normally.

Configuration
REQ-026 With macro BCD2BIN_RANGE_CHECK_EN defined:
  - any captured digit >9 SHALL set err=1 in the done cycle.
  - number=0 and ovf8=0 in that case.
  - latency is unchanged.
REQ-027 Without BCD2BIN_RANGE_CHECK_EN:
  - err SHALL be tied to 0.
  - invalid digits produce an unspecified number with normal timing.

Structure
REQ-028 Shared package bcd_pkg SHALL hold:
  - BCD_DIGITS=3, BIN_W=10, ITERS=10.
  - the FSM state enum type.
  - the 4-bit bcd_digit_t typedef.
REQ-029 Sub-module bcd_digit_adjust SHALL implement the per-nibble rule (>=8 subtract 3), instantiated 3 times.

Verification
REQ-030 start with 2,5,5 -> done exactly 11 cycles later, number=255, ovf8=0, err=0.
REQ-031 start with 9,9,9 -> number=999, ovf8=1; then 0,0,0 -> number=0, ovf8=0.
REQ-032 start with 1,2,8 and a second start at N+4 with 3,0,0 -> second start ignored; number=128 at N+11, one done pulse only.
REQ-033 start with 4,2,0, rst_n low at N+5 for 1 cycle:
  - all outputs 0, no done pulse.
  - a later start with 0,4,2 gives number=42.
REQ-034 With BCD2BIN_RANGE_CHECK_EN, start with 0,10,3 (tens=4'hA) -> err=1, number=0 at N+11; then 0,1,3 -> err=0, number=13.
REQ-035 Exhaustive sweep of all 1000 valid digit triples -> number matches the decimal value, ovf8 correct in every case.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter: widths, iteration
// count, FSM state encoding and the BCD digit type.
package bcd_pkg;

  localparam int BCD_DIGITS = 3;
  localparam int BIN_W      = 10;
  localparam int ITERS      = 10;
  localparam int SREG_W     = BIN_W + 4 * BCD_DIGITS;  // 22-bit working register
  localparam int CNT_W      = 4;

  localparam logic [BIN_W-1:0] OVF8_LIMIT = 10'd255;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // A BCD digit is legal only in the range 0..9.
  function automatic logic digit_valid(input bcd_digit_t d);
    return d <= bcd_digit_t'(9);
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-nibble correction for reverse double-dabble: after the right shift,
// a nibble holding 8 or more has borrowed a half-ten from the digit above
// and must be reduced by 3 to stay a valid BCD digit.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  output bcd_digit_t adjusted
);

  assign adjusted = (digit >= bcd_digit_t'(8)) ? digit - bcd_digit_t'(3) : digit;

endmodule

// File: rtl/bcd_to_binary.sv
// Three-digit BCD to 10-bit binary converter using reverse double-dabble.
// A start in IDLE captures the digits; ten shift/adjust iterations follow,
// then a single-cycle done pulse presents number/ovf8/err, which are held
// until the next conversion completes.
// Optional feature: define BCD2BIN_RANGE_CHECK_EN to flag digits above 9
// through err (number and ovf8 are forced to 0 in that case).
module bcd_to_binary
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic       busy,
  output logic       done,
  output logic [9:0] number,
  output logic       ovf8,
  output logic       err
);

  state_t            state, state_nx;
  logic [SREG_W-1:0] sreg, shifted, sreg_nx;
  logic [CNT_W-1:0]  cnt;
  logic [BIN_W-1:0]  result;
  logic              accept, last_iter, bad_digits;

  assign accept    = (state == IDLE) && start;
  assign last_iter = (state == SHIFT) && (cnt == CNT_W'(ITERS - 1));

  // One iteration: shift right, then correct each BCD nibble independently.
  assign shifted = sreg >> 1;

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit    (shifted[BIN_W + 4*i +: 4]),
      .adjusted (sreg_nx[BIN_W + 4*i +: 4])
    );
  end

  assign sreg_nx[BIN_W-1:0] = shifted[BIN_W-1:0];
  assign result             = sreg_nx[BIN_W-1:0];

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: IDLE -> SHIFT on start, SHIFT -> DONE after the last
  // iteration, DONE -> IDLE unconditionally.
  always_comb begin
    // NOTE: default first so no path leaves state_nx unassigned (no latch).
    state_nx = state;
    unique case (state)
      IDLE:    if (start)     state_nx = SHIFT;
      SHIFT:   if (last_iter) state_nx = DONE;
      DONE:                   state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Working register and iteration counter: load on accept, step in SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sreg <= '0;
    end else if (accept) begin
      cnt  <= '0;
      sreg <= {hundreds, tens, ones, {BIN_W{1'b0}}};
    end else if (state == SHIFT) begin
      cnt  <= cnt + 1'b1;
      sreg <= sreg_nx;
    end
  end

  // Result registers: written once, on the final iteration, then held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      number <= '0;
      ovf8   <= 1'b0;
    end else if (last_iter) begin
      number <= bad_digits ? '0 : result;
      ovf8   <= !bad_digits && (result > OVF8_LIMIT);
    end
  end

`ifdef BCD2BIN_RANGE_CHECK_EN
  logic bad_q, err_q;

  // Remember whether any captured digit was out of range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      bad_q <= 1'b0;
    else if (accept) bad_q <= !(digit_valid(hundreds) && digit_valid(tens) &&
                                digit_valid(ones));
  end

  // Publish the range flag alongside the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         err_q <= 1'b0;
    else if (last_iter) err_q <= bad_q;
  end

  assign bad_digits = bad_q;
  assign err        = err_q;
`else
  assign bad_digits = 1'b0;
  assign err        = 1'b0;
`endif

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule
